// File: rtl/demux_pkg.sv
// Shared constants and types for the buffered 1-to-4 result demultiplexer.
package demux_pkg;
  localparam int CH_NUM     = 4;
  localparam int SEL_W      = 2;
  localparam int FIFO_DEPTH = 2;

  typedef logic [1:0] cnt_t;
endpackage

// File: rtl/demux_chan_fifo.sv
// Two-entry channel FIFO; pushed word visible one cycle after the push edge.
// Backpressure: full refuses push, pop on empty is ignored; push+pop together keeps occupancy.
module demux_chan_fifo
  import demux_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [N-1:0] wdata,
  output logic [N-1:0] rdata,
  output logic         valid,
  output logic         full
);

  logic [N-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  cnt_t         cnt_q, cnt_d;
  logic         push_ok, pop_ok;

  assign valid   = (cnt_q != cnt_t'(0));
  assign full    = (cnt_q == cnt_t'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && valid;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_ok) wr_ptr_d = ~wr_ptr_q;
    if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + cnt_t'(1);
      2'b01:   cnt_d = cnt_q - cnt_t'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/demux_1to4_buf.sv
// Routes one input word per cycle by sel into one of four 2-entry FIFOs; 1-cycle latency.
// Backpressure: in_ready reflects only the selected channel's fullness, never out_ready.
module demux_1to4_buf
  import demux_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_data,
  input  logic [SEL_W-1:0] sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     out0,
  output logic [N-1:0]     out1,
  output logic [N-1:0]     out2,
  output logic [N-1:0]     out3,
  output logic [CH_NUM-1:0] out_valid,
  input  logic [CH_NUM-1:0] out_ready
);

  logic [N-1:0]      chan_rdata [CH_NUM];
  logic [CH_NUM-1:0] chan_full;
  logic [CH_NUM-1:0] chan_push;

  assign in_ready = rst_n && !chan_full[sel];

  for (genvar k = 0; k < CH_NUM; k++) begin : g_chan
    assign chan_push[k] = in_valid && in_ready && (sel == SEL_W'(k));

    demux_chan_fifo #(
      .N     (N),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (chan_push[k]),
      .pop   (out_ready[k]),
      .wdata (in_data),
      .rdata (chan_rdata[k]),
      .valid (out_valid[k]),
      .full  (chan_full[k])
    );
  end

  assign out0 = chan_rdata[0];
  assign out1 = chan_rdata[1];
  assign out2 = chan_rdata[2];
  assign out3 = chan_rdata[3];

endmodule
